lc3_mem_arbiter: RTL and testbench

Two-requester memory arbiter and access sequencer for the SLC-3 system. It shares the single-port on-chip memory between two requesters:
- the CPU datapath (MAR/MDR path);
- a debug/loader port (program load, switch-driven memory inspect).

It serialises accesses, inserts MEM_LAT wait cycles per access and returns a one-cycle acknowledge with read data to the winning requester.

---
 rtl/lc3_mem_arbiter_pkg.sv | 11 +
 rtl/lc3_mem_arbiter_if.sv | 51 +++++
 rtl/lc3_mem_arbiter_rr_pick.sv | 28 ++
 rtl/lc3_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and defaults for the SLC-3 memory arbiter slice.
package lc3_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned LAT_CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester, memory and status signals of the arbiter; slave = arbiter side.
interface lc3_mem_arbiter_if
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;
  logic              dbg_lock;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant_dbg;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    output busy, grant_dbg
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    input  busy, grant_dbg
  );

endinterface

// File: rtl/lc3_mem_arbiter_rr_pick.sv
// Combinational two-way round-robin pick; dbg_lock starves the CPU entirely.
module lc3_rr_pick
  import lc3_mem_pkg::*;
(
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  logic    dbg_lock,
  input  req_id_t rr_last,
  output logic    valid,
  output req_id_t winner
);

  always_comb begin
    valid  = 1'b0;
    winner = REQ_CPU;
    if (dbg_lock) begin
      valid  = dbg_req;
      winner = REQ_DBG;
    end else if (cpu_req && dbg_req) begin
      valid  = 1'b1;
      winner = (rr_last == REQ_CPU) ? REQ_DBG : REQ_CPU;
    end else begin
      valid  = cpu_req || dbg_req;
      winner = dbg_req ? REQ_DBG : REQ_CPU;
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port SLC-3 memory between CPU and debug/loader requesters,
// holding each access for MEM_LAT cycles and returning a one-cycle ack.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic               Clk,
  input  logic               Reset_n,
  lc3_mem_arbiter_if.slave   bus
);

  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(MEM_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  arb_state_t           state;
  req_id_t              winner;
  req_id_t              rr_last;
  logic [LAT_CNT_W-1:0] cnt;

  logic              mem_ce_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;
  logic              busy_q;
  logic              grant_dbg_q;

  logic              pick_valid;
  req_id_t           pick_winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  lc3_rr_pick u_pick (
    .cpu_req  (bus.cpu_req),
    .dbg_req  (bus.dbg_req),
    .dbg_lock (bus.dbg_lock),
    .rr_last  (rr_last),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (pick_winner == REQ_DBG) begin
      sel_we    = bus.dbg_we;
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
    end
  end

  // Outputs are registered alongside the state so ce/we/ack line up with ACCESS/DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      winner      <= REQ_CPU;
      rr_last     <= REQ_DBG;
      cnt         <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      grant_dbg_q <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            winner      <= pick_winner;
            grant_dbg_q <= (pick_winner == REQ_DBG);
            mem_ce_q    <= 1'b1;
            mem_we_q    <= sel_we;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            cnt         <= CNT_LOAD;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!mem_we_q) begin
              if (winner == REQ_DBG) dbg_rdata_q <= bus.mem_rdata;
              else                   cpu_rdata_q <= bus.mem_rdata;
            end
            if (winner == REQ_DBG) dbg_ack_q <= 1'b1;
            else                   cpu_ack_q <= 1'b1;
            mem_ce_q <= 1'b0;
            mem_we_q <= 1'b0;
            state    <= DONE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          rr_last <= winner;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_ce    = mem_ce_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant_dbg = grant_dbg_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_lc3_mem_arbiter;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  lc3_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .bus(ifa.slave)
  );
  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .bus(ifb.slave)
  );

  // 256-word memory models, indexed by the low address byte
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge Clk) begin
    if (pre_we) begin
      mem_a[pre_addr] <= pre_data;
      mem_b[pre_addr] <= pre_data;
    end else begin
      if (ifa.mem_ce && ifa.mem_we) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
      if (ifb.mem_ce && ifb.mem_we) mem_b[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
    end
  end

  assign ifa.mem_rdata = mem_a[ifa.mem_addr[7:0]];
  assign ifb.mem_rdata = mem_b[ifb.mem_addr[7:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic idle_inputs();
    ifa.cpu_req = 1'b0; ifa.cpu_we = 1'b0; ifa.cpu_addr = '0; ifa.cpu_wdata = '0;
    ifa.dbg_req = 1'b0; ifa.dbg_we = 1'b0; ifa.dbg_addr = '0; ifa.dbg_wdata = '0;
    ifa.dbg_lock = 1'b0;
    ifb.cpu_req = 1'b0; ifb.cpu_we = 1'b0; ifb.cpu_addr = '0; ifb.cpu_wdata = '0;
    ifb.dbg_req = 1'b0; ifb.dbg_we = 1'b0; ifb.dbg_addr = '0; ifb.dbg_wdata = '0;
    ifb.dbg_lock = 1'b0;
  endtask

  initial begin
    int ncpu;
    int ndbg;
    Reset_n  = 1'b0;
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    idle_inputs();
    step();
    preload(8'h05, 16'h1234);
    preload(8'h40, 16'h0A0A);
    preload(8'h41, 16'h0B0B);
    preload(8'hFF, 16'h5A5A);

    check("rst_mem_ce",    ifa.mem_ce,    0);
    check("rst_mem_we",    ifa.mem_we,    0);
    check("rst_mem_addr",  ifa.mem_addr,  0);
    check("rst_busy",      ifa.busy,      0);
    check("rst_cpu_ack",   ifa.cpu_ack,   0);
    check("rst_dbg_ack",   ifa.dbg_ack,   0);
    check("rst_cpu_rdata", ifa.cpu_rdata, 0);
    check("rst_dbg_rdata", ifa.dbg_rdata, 0);
    check("rst_grant_dbg", ifa.grant_dbg, 0);
    Reset_n = 1'b1;

    // CPU read of 0x0005; this interval is cycle 0
    ifa.cpu_req = 1'b1; ifa.cpu_we = 1'b0; ifa.cpu_addr = 16'h0005;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("t1_mem_ce",  ifa.mem_ce,  (c == 1 || c == 2));
      check("t1_cpu_ack", ifa.cpu_ack, (c == 3));
      check("t1_dbg_ack", ifa.dbg_ack, 0);
      check("t1_busy",    ifa.busy,    (c <= 3));
      if (c == 1) check("t1_mem_addr", ifa.mem_addr, 16'h0005);
      if (c == 3) begin
        check("t1_cpu_rdata", ifa.cpu_rdata, 16'h1234);
        ifa.cpu_req = 1'b0;
      end
    end

    // Debug write 0x0031 <= 0xBEEF, then CPU reads it back
    ifa.dbg_req = 1'b1; ifa.dbg_we = 1'b1; ifa.dbg_addr = 16'h0031; ifa.dbg_wdata = 16'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t2w_mem_we",  ifa.mem_we,  (c <= 2));
      check("t2w_dbg_ack", ifa.dbg_ack, (c == 3));
      if (c == 3) begin
        check("t2w_dbg_rdata", ifa.dbg_rdata, 0);
        check("t2w_grant_dbg", ifa.grant_dbg, 1);
        ifa.dbg_req = 1'b0; ifa.dbg_we = 1'b0;
      end
    end
    step();
    ifa.cpu_req = 1'b1; ifa.cpu_we = 1'b0; ifa.cpu_addr = 16'h0031;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t2r_mem_we",  ifa.mem_we,  0);
      check("t2r_cpu_ack", ifa.cpu_ack, (c == 3));
      if (c == 3) begin
        check("t2r_cpu_rdata", ifa.cpu_rdata, 16'hBEEF);
        check("t2r_dbg_rdata", ifa.dbg_rdata, 0);
        check("t2r_grant_dbg", ifa.grant_dbg, 0);
        ifa.cpu_req = 1'b0;
      end
    end

    // Reset, then both requesters held high: CPU, DBG, CPU, DBG
    Reset_n = 1'b0;
    step();
    check("t3_rst_cpu_rdata", ifa.cpu_rdata, 0);
    check("t3_rst_busy",      ifa.busy,      0);
    Reset_n = 1'b1;
    ifa.cpu_req = 1'b1; ifa.cpu_addr = 16'h0040;
    ifa.dbg_req = 1'b1; ifa.dbg_addr = 16'h0041;
    for (int c = 1; c <= 15; c++) begin
      step();
      check("t3_cpu_ack", ifa.cpu_ack, (c == 3 || c == 11));
      check("t3_dbg_ack", ifa.dbg_ack, (c == 7 || c == 15));
      if (c == 3 || c == 7 || c == 11 || c == 15)
        check("t3_grant_dbg", ifa.grant_dbg, (c == 7 || c == 15));
    end
    ifa.cpu_req = 1'b0; ifa.dbg_req = 1'b0;
    check("t3_cpu_rdata", ifa.cpu_rdata, 16'h0A0A);
    check("t3_dbg_rdata", ifa.dbg_rdata, 16'h0B0B);
    step();
    check("t3_idle_busy", ifa.busy, 0);

    // dbg_lock with both requests held: only debug is served
    ifa.dbg_lock = 1'b1; ifa.cpu_req = 1'b1; ifa.dbg_req = 1'b1;
    ncpu = 0;
    ndbg = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      ncpu += int'(ifa.cpu_ack);
      ndbg += int'(ifa.dbg_ack);
    end
    check("t4_cpu_acks", ncpu, 0);
    check("t4_dbg_acks", ndbg, 5);
    check("t4_busy_idle", ifa.busy, 0);
    ifa.dbg_lock = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t4_unlock_cpu_ack", ifa.cpu_ack, (c == 3));
      check("t4_unlock_dbg_ack", ifa.dbg_ack, 0);
      if (c == 3) check("t4_unlock_grant", ifa.grant_dbg, 0);
    end
    ifa.cpu_req = 1'b0; ifa.dbg_req = 1'b0;

    // Reset during the second ACCESS cycle of a CPU read
    step();
    ifa.cpu_req = 1'b1; ifa.cpu_addr = 16'h0005;
    step();
    step();
    check("t5_pre_mem_ce", ifa.mem_ce, 1);
    Reset_n = 1'b0;
    #1;
    check("t5_rst_mem_ce",    ifa.mem_ce,    0);
    check("t5_rst_busy",      ifa.busy,      0);
    check("t5_rst_cpu_ack",   ifa.cpu_ack,   0);
    check("t5_rst_cpu_rdata", ifa.cpu_rdata, 0);
    @(posedge Clk);
    #1;
    check("t5_held_cpu_ack", ifa.cpu_ack, 0);
    Reset_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("t5_cpu_ack", ifa.cpu_ack, (c == 3));
      if (c == 3) check("t5_cpu_rdata", ifa.cpu_rdata, 16'h1234);
    end
    ifa.cpu_req = 1'b0;

    // MEM_LAT=1 instance: back-to-back reads of 0xFFFF
    ifb.cpu_req = 1'b1; ifb.cpu_we = 1'b0; ifb.cpu_addr = 16'hFFFF;
    for (int c = 1; c <= 8; c++) begin
      step();
      check("t6_cpu_ack", ifb.cpu_ack, (c == 2 || c == 5 || c == 8));
      check("t6_mem_ce",  ifb.mem_ce,  (c == 1 || c == 4 || c == 7));
      if (c == 1) check("t6_mem_addr", ifb.mem_addr, 16'hFFFF);
      if (c == 2) check("t6_cpu_rdata", ifb.cpu_rdata, 16'h5A5A);
    end
    ifb.cpu_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
